// File: rtl/rat_pkg.sv
// Shared types and constants for the flag / interrupt unit.
// Imported by flag_int_unit and int_sync.
package rat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERV
    } int_state_t;

    localparam logic LD_SEL_ALU  = 1'b0;
    localparam logic LD_SEL_SHAD = 1'b1;

endpackage

// File: rtl/int_sync.sv
// Synchroniser chain for the external interrupt line plus an event detector.
// The detector works on rising edges or on the level, depending on EDGE_MODE.
module int_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic int_in,
    output logic s,
    output logic evt
);
    import rat_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], int_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_MODE) begin : g_edge
            assign evt = s & ~prev_q;
        end else begin : g_level
            assign evt = s;
        end
    endgenerate

endmodule

// File: rtl/flag_int_unit.sv
// C/Z flags with shadow copies, interrupt enable and the interrupt
// request FSM that talks to the control unit.
module flag_int_unit #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic INT_IN,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_CU,
    output logic IN_SERVICE
);
    import rat_pkg::*;

    logic       c_q, c_d;
    logic       z_q, z_d;
    logic       shad_c_q, shad_c_d;
    logic       shad_z_q, shad_z_d;
    logic       i_q, i_d;
    logic       queued_q, queued_d;
    int_state_t state_q, state_d;
    logic       sync_s;
    logic       evt;
    logic       isr_ret;

    int_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (EDGE_MODE)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RESET),
        .int_in(INT_IN),
        .s     (sync_s),
        .evt   (evt)
    );

    always_comb begin
        c_d      = c_q;
        z_d      = z_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        i_d      = i_q;

        if (FLG_C_CLR)
            c_d = 1'b0;
        else if (FLG_C_SET)
            c_d = 1'b1;
        else if (FLG_C_LD)
            c_d = (FLG_LD_SEL == LD_SEL_SHAD) ? shad_c_q : ALU_C;

        if (FLG_Z_LD)
            z_d = (FLG_LD_SEL == LD_SEL_SHAD) ? shad_z_q : ALU_Z;

        // Shadow captures the pre-update flags, so load+save is a swap.
        if (FLG_SHAD_LD) begin
            shad_c_d = c_q;
            shad_z_d = z_q;
        end

        if (I_CLR || INT_ACK)
            i_d = 1'b0;
        else if (I_SET)
            i_d = 1'b1;
    end

    assign isr_ret = I_SET | I_CLR;

    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        unique case (state_q)
            ST_IDLE: begin
                if (evt)
                    state_d = ST_PEND;
            end
            ST_PEND: begin
                if (INT_ACK) begin
                    state_d = ST_SERV;
                    if (evt)
                        queued_d = 1'b1;
                end
            end
            ST_SERV: begin
                if (isr_ret) begin
                    state_d  = (queued_q || evt) ? ST_PEND : ST_IDLE;
                    queued_d = 1'b0;
                end else if (evt) begin
                    queued_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                queued_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
            i_q      <= 1'b0;
            queued_q <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
            i_q      <= i_d;
            queued_q <= queued_d;
            state_q  <= state_d;
        end
    end

    assign C_FLAG     = c_q;
    assign Z_FLAG     = z_q;
    assign I_FLAG     = i_q;
    assign INT_CU     = (state_q == ST_PEND) & i_q;
    assign IN_SERVICE = (state_q == ST_SERV);

endmodule

// File: tb/tb_flag_int_unit.sv
// Directed bench for flag_int_unit: flag/I vector table plus
// hand-written interrupt latency, masking, queueing and reset sequences.
module tb_flag_int_unit;

    logic CLK = 1'b0;
    logic RESET;
    logic ALU_C, ALU_Z;
    logic FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
    logic FLG_LD_SEL, FLG_SHAD_LD;
    logic I_SET, I_CLR, INT_ACK, INT_IN;
    logic C_FLAG, Z_FLAG, I_FLAG, INT_CU, IN_SERVICE;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    flag_int_unit #(
        .SYNC_STAGES(2),
        .EDGE_MODE  (1'b1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALU_C      (ALU_C),
        .ALU_Z      (ALU_Z),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_LD_SEL (FLG_LD_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET      (I_SET),
        .I_CLR      (I_CLR),
        .INT_ACK    (INT_ACK),
        .INT_IN     (INT_IN),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .I_FLAG     (I_FLAG),
        .INT_CU     (INT_CU),
        .IN_SERVICE (IN_SERVICE)
    );

    // in = {rst_n, alu_c, alu_z, c_set, c_clr, c_ld, z_ld, sel, shad_ld,
    //       i_set, i_clr, int_ack}; ex = {c, z, i, int_cu, in_service}
    typedef struct {
        string      name;
        logic [11:0] in;
        logic [4:0]  ex;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        RESET = 1'b1;
        {ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD} = '0;
        {FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK} = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input logic [11:0] in);
        {RESET, ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD,
         FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK} = in;
    endtask

    task automatic check_all(input string name, input logic [4:0] ex);
        check({name, ".C"},   C_FLAG,     ex[4]);
        check({name, ".Z"},   Z_FLAG,     ex[3]);
        check({name, ".I"},   I_FLAG,     ex[2]);
        check({name, ".CU"},  INT_CU,     ex[1]);
        check({name, ".SRV"}, IN_SERVICE, ex[0]);
    endtask

    initial begin
        vecs[0]  = '{"rst_all_hi", 12'b0_11_111_1_1_1_1_1_1, 5'b00000};
        vecs[1]  = '{"rst_rel",    12'b1_00_000_0_0_0_0_0_0, 5'b00000};
        vecs[2]  = '{"c_prio_clr", 12'b1_10_111_0_0_0_0_0_0, 5'b00000};
        vecs[3]  = '{"c_set",      12'b1_00_100_0_0_0_0_0_0, 5'b10000};
        vecs[4]  = '{"c_ld_alu",   12'b1_00_001_0_0_0_0_0_0, 5'b00000};
        vecs[5]  = '{"z_ld_alu",   12'b1_01_000_1_0_0_0_0_0, 5'b01000};
        vecs[6]  = '{"shad_save",  12'b1_00_000_0_0_1_0_0_0, 5'b01000};
        vecs[7]  = '{"c1_z0",      12'b1_00_100_1_0_0_0_0_0, 5'b10000};
        vecs[8]  = '{"swap",       12'b1_10_001_1_1_1_0_0_0, 5'b01000};
        vecs[9]  = '{"ld_shad",    12'b1_01_001_1_1_0_0_0_0, 5'b10000};
        vecs[10] = '{"z_ld_hold_c",12'b1_01_000_1_0_0_0_0_0, 5'b11000};
        vecs[11] = '{"i_set",      12'b1_00_000_0_0_0_1_0_0, 5'b11100};
        vecs[12] = '{"i_clr_prio", 12'b1_00_000_0_0_0_1_1_0, 5'b11000};
        vecs[13] = '{"i_set2",     12'b1_00_000_0_0_0_1_0_0, 5'b11100};
        vecs[14] = '{"ack_over_set",12'b1_00_000_0_0_0_1_0_1, 5'b11000};
        vecs[15] = '{"i_set3",     12'b1_00_000_0_0_0_1_0_0, 5'b11100};

        idle_inputs();
        INT_IN = 1'b0;
        #1;
        // Strobes high with reset inactive before the first reset edge.
        apply(12'b1_11_111_1_1_1_1_1_1);
        repeat (3) tick();

        for (int k = 0; k < 16; k++) begin
            apply(vecs[k].in);
            tick();
            check_all(vecs[k].name, vecs[k].ex);
        end

        // Interrupt latency with I=1 and C=Z=1 held.
        idle_inputs();
        INT_IN = 1'b1;
        tick();
        check("lat_e1", INT_CU, 1'b0);
        tick();
        check("lat_e2", INT_CU, 1'b0);
        tick();
        check("lat_e3", INT_CU, 1'b1);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check_all("ack_e4", 5'b11001);

        // Return without a queued event goes idle.
        INT_IN = 1'b0;
        repeat (3) tick();
        I_SET = 1'b1;
        tick();
        I_SET = 1'b0;
        check_all("ret_idle", 5'b11100);
        repeat (2) tick();
        check("ret_idle_cu", INT_CU, 1'b0);

        // Masked request stays pending until I is set.
        I_CLR = 1'b1;
        tick();
        I_CLR = 1'b0;
        INT_IN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mask_cu", INT_CU, 1'b0);
        end
        INT_IN = 1'b0;
        repeat (10) tick();
        check("mask_wait_cu", INT_CU, 1'b0);
        I_SET = 1'b1;
        tick();
        I_SET = 1'b0;
        check("mask_release_cu", INT_CU, 1'b1);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check_all("mask_ack", 5'b11001);

        // Second edge during the ISR is queued and replayed on return.
        INT_IN = 1'b1;
        repeat (3) tick();
        INT_IN = 1'b0;
        repeat (3) tick();
        check_all("q_in_serv", 5'b11001);
        I_SET = 1'b1;
        tick();
        I_SET = 1'b0;
        check_all("q_replay", 5'b11110);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check_all("q_ack2", 5'b11001);

        // Same again, but reset in the middle of the ISR.
        INT_IN = 1'b1;
        repeat (3) tick();
        INT_IN = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check_all("isr_rst", 5'b00000);
        repeat (3) tick();
        I_SET = 1'b1;
        tick();
        I_SET = 1'b0;
        check_all("rst_no_queue", 5'b00100);
        tick();
        check("rst_no_queue_cu", INT_CU, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_int_unit.md
Name: flag_int_unit

Overview:
- Holds the CPU's C and Z flags, their shadow copies, and the interrupt-enable (I) flag.
- Synchronises the external interrupt line and qualifies it with I.
- Feeds C_FLAG, Z_FLAG and INT_CU to the control unit, and consumes that unit's FLG_*, I_SET/I_CLR and INT_ACK strobes.
- Sits between the ALU/control unit and the external interrupt source.

Parameters:
- SYNC_STAGES, 2, number of flops in the INT_IN synchroniser (legal values 2..3).
- EDGE_MODE, 1, 1 = rising-edge-triggered interrupt; 0 = level-triggered.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- ALU_C  in  1  carry result from ALU.
- ALU_Z  in  1  zero result from ALU.
- FLG_C_SET  in  1  force C=1.
- FLG_C_CLR  in  1  force C=0.
- FLG_C_LD  in  1  load C from the selected source.
- FLG_Z_LD  in  1  load Z from the selected source.
- FLG_LD_SEL  in  1  load source select: 0 = ALU, 1 = shadow register.
- FLG_SHAD_LD  in  1  copy current C/Z into the shadow registers.
- I_SET  in  1  enable interrupts (SEI / RETIE).
- I_CLR  in  1  disable interrupts (CLI / RETID).
- INT_ACK  in  1  control unit is entering the ISR this cycle.
- INT_IN  in  1  asynchronous external interrupt request.
- C_FLAG  out  1  registered carry flag.
- Z_FLAG  out  1  registered zero flag.
- I_FLAG  out  1  registered interrupt enable.
- INT_CU  out  1  interrupt request to control unit.
- IN_SERVICE  out  1  high while an ISR is executing.

Behaviour:
- Reset (RESET==0 at a CLK edge): C, Z, SHAD_C, SHAD_Z, I, the synchroniser chain, the edge history and the queued bit all clear to 0; FSM goes to ST_IDLE; every output is 0. Reset overrides all other inputs in the same cycle, including mid-ISR.
- C update priority: FLG_C_CLR > FLG_C_SET > FLG_C_LD.
  - On load, C <= FLG_LD_SEL ? SHAD_C : ALU_C.
  - No strobe asserted: C holds.
- Z update: on FLG_Z_LD, Z <= FLG_LD_SEL ? SHAD_Z : ALU_Z; otherwise Z holds.
- Shadow update: on FLG_SHAD_LD, SHAD_C/SHAD_Z <= pre-update C/Z.
  - Simultaneous FLG_SHAD_LD and FLG_C_LD with FLG_LD_SEL=1: the shadow takes the old flag, the flag takes the old shadow (swap).
- I update priority: I_CLR > I_SET. INT_ACK also forces I <= 0, and wins over I_SET in the same cycle.
- Synchroniser: SYNC_STAGES flops clocked by CLK. Its output is S.
  - EDGE_MODE=1: event = S & ~S_prev.
  - EDGE_MODE=0: event = S.
- FSM states: ST_IDLE, ST_PEND, ST_SERV.
  - ST_IDLE -> ST_PEND on event.
  - ST_PEND -> ST_SERV on INT_ACK. An event in the same cycle sets queued=1.
  - ST_SERV -> ST_PEND on I_SET or I_CLR (ISR return) when queued=1 or event; queued is cleared on exit.
  - ST_SERV -> ST_IDLE on I_SET or I_CLR when queued=0 and no event.
  - An event while in ST_SERV sets queued=1. Only one event is queued; further events are dropped.
  - An event while in ST_PEND is absorbed (no counting).
  - INT_ACK outside ST_PEND is ignored for the FSM but still clears I.
- Outputs:
  - INT_CU = (state==ST_PEND) & I, decoded from registers only. INT_CU never depends combinationally on any input.
  - IN_SERVICE = (state==ST_SERV).
- Latency (SYNC_STAGES=2, EDGE_MODE=1, I=1): INT_IN rises before edge e1 -> INT_CU high after e3.
  - If I=0, the request stays pending and INT_CU rises the cycle after the edge at which I becomes 1.
- Level mode: in ST_IDLE with S still high after return, the FSM re-enters ST_PEND on the next edge.

Decomposition:
- Shared package rat_pkg:
  - typedef enum int_state_t {ST_IDLE, ST_PEND, ST_SERV};
  - constants LD_SEL_ALU=0, LD_SEL_SHAD=1.
- Sub-module int_sync: parameterised synchroniser chain plus edge/level event detector, with outputs S and event. Flag registers and the FSM stay in flag_int_unit.

Test Plan:
- Reset:
  - Drive all flag/I strobes high with RESET=1 for 3 cycles; then hold RESET=0 for one edge -> C,Z,I,INT_CU,IN_SERVICE all 0 after that edge.
  - Release RESET -> outputs stay 0 with no strobes.
- Flag priority:
  - ALU_C=1, FLG_C_CLR=1, FLG_C_SET=1, FLG_C_LD=1 -> C=0.
  - Next cycle FLG_C_SET only -> C=1.
  - Next cycle FLG_C_LD, ALU_C=0 -> C=0.
- Shadow swap:
  - C=1, Z=0, SHAD_C=0, SHAD_Z=1; assert FLG_SHAD_LD, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL=1 together -> C=0, Z=1, SHAD_C=1, SHAD_Z=0.
- Interrupt latency:
  - I=1; INT_IN 0->1 before edge e1 -> INT_CU=1 after e3.
  - INT_ACK at e4 -> INT_CU=0, I=0, IN_SERVICE=1 after e4.
- Masked request:
  - I=0; pulse INT_IN high for 4 cycles -> INT_CU stays 0.
  - I_SET 10 cycles later -> INT_CU=1 one edge after I_SET.
- Queued event and mid-ISR reset:
  - In ST_SERV, a second INT_IN rising edge occurs; then I_SET -> state ST_PEND, INT_CU=1 the following cycle.
  - Repeat, but hold RESET=0 instead of I_SET -> ST_IDLE and queued cleared.
